// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_drv: nibble/dp load inputs, live mode controls, and active-low pin outputs.
// master = the datapath/testbench driving the inputs; slave = the scan driver.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    hex_mode;
  logic                    blank_lz;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;

  modport master (
    output value, load, dp_in, hex_mode, blank_lz,
    input  seg_n, dp_n, an_n
  );

  modport slave (
    input  value, load, dp_in, hex_mode, blank_lz,
    output seg_n, dp_n, an_n
  );
endinterface

// File: rtl/seg_scan_drv.sv
// Scans a shadowed nibble vector across NUM_DIGITS common-anode digits, with a blanking gap at the start of each slot.
// Pins are registered (1-cycle latency); there is no backpressure, and a load may come on any cycle.
module seg_scan_drv #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [31:0]   BLANK_W = BLANK_CYC;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [VW-1:0]         act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

  logic       wrap;
  logic       blank;
  logic       all_zero;
  logic       lz_blank;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic [31:0] cnt_ext;

  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = hex ? 7'b0001000 : 7'b1111110;
      4'hB: s = hex ? 7'b1100000 : 7'b1111110;
      4'hC: s = hex ? 7'b0110001 : 7'b1111110;
      4'hD: s = hex ? 7'b1000010 : 7'b1111110;
      4'hE: s = hex ? 7'b0110000 : 7'b1111110;
      default: s = hex ? 7'b0111000 : 7'b1111110;
    endcase
    return s;
  endfunction

  // Slot timing and shadow registers: act only ever changes on a slot boundary.
  always_comb begin
    wrap       = (cnt_q == CNT_MAX);
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    pend_val_d = bus.load ? bus.value : pend_val_q;
    pend_dp_d  = bus.load ? bus.dp_in : pend_dp_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    if (wrap) begin
      act_val_d = bus.load ? bus.value : pend_val_q;
      act_dp_d  = bus.load ? bus.dp_in : pend_dp_q;
    end
  end

  // Digit select and leading-zero detection walk from the most significant digit down.
  always_comb begin
    cnt_ext  = 32'(cnt_q);
    blank    = (cnt_ext < BLANK_W);
    all_zero = 1'b1;
    lz_blank = 1'b0;
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    an_n_d   = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (act_val_q[4*i +: 4] == 4'h0);
      if (IW'(i) == idx_q) begin
        cur_nib  = act_val_q[4*i +: 4];
        cur_dp   = act_dp_q[i];
        lz_blank = bus.blank_lz && (i != 0) && all_zero;
        an_n_d[i] = blank;
      end
    end
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (!blank) begin
      seg_n_d = lz_blank ? 7'h7F : decode(cur_nib, bus.hex_mode);
      dp_n_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      seg_n_q    <= 7'h7F;
      dp_n_q     <= 1'b1;
      an_n_q     <= '1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      seg_n_q    <= seg_n_d;
      dp_n_q     <= dp_n_d;
      an_n_q     <= an_n_d;
    end
  end

  assign bus.seg_n = seg_n_q;
  assign bus.dp_n  = dp_n_q;
  assign bus.an_n  = an_n_q;
endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv (4 digits, 8-cycle slots, 2-cycle blanking gap).
// Stimulus queues the expected pin state of each upcoming lit slot; the monitor checks every cycle against it.
module tb_seg_scan_drv;
  logic clk;
  logic rst_n;

  seg_scan_if #(.NUM_DIGITS(4)) bus();

  seg_scan_drv #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .BLANK_CYC  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got {an,seg,dp}=%03h expected %03h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void push(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    q.push_back(e);
  endfunction

  // Monitor: samples 3 time units after each rising edge.
  initial begin
    exp_t       cur;
    logic       cur_vld;
    logic [3:0] prev_an;
    cur     = '0;
    cur_vld = 1'b0;
    prev_an = 4'hF;
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        chk("reset_dark", {bus.an_n, bus.seg_n, bus.dp_n}, {4'hF, 7'h7F, 1'b1});
        cur_vld = 1'b0;
      end else if (bus.an_n == 4'hF) begin
        chk("blank_gap", {bus.an_n, bus.seg_n, bus.dp_n}, {4'hF, 7'h7F, 1'b1});
      end else begin
        if (prev_an == 4'hF) begin
          cur_vld = (q.size() != 0);
          if (cur_vld) cur = q.pop_front();
        end
        if (cur_vld) chk("slot", {bus.an_n, bus.seg_n, bus.dp_n}, cur);
      end
      prev_an = bus.an_n;
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d slots still expected", q.size());
      q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  // Reset, load v right after release, then expect: idx0 still showing zero, then digits 1,2,3,0 of v.
  task automatic run(input logic [15:0] v, input logic [3:0] dp, input logic hex, input logic lz,
                     input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    @(negedge clk);
    rst_n    = 1'b0;
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    bus.value    = v;
    bus.dp_in    = dp;
    bus.hex_mode = hex;
    bus.blank_lz = lz;
    push(4'hE, 7'h01, 1'b1);
    push(4'hD, s1, ~dp[1]);
    push(4'hB, s2, ~dp[2]);
    push(4'h7, s3, ~dp[3]);
    push(4'hE, s0, ~dp[0]);
    rst_n = 1'b1;
    @(negedge clk);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    drain();
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.dp_in    = '0;
    bus.hex_mode = 1'b0;
    bus.blank_lz = 1'b0;

    // T1: dark in reset; first lit digit BLANK_CYC+1 edges after release
    repeat (3) @(negedge clk);
    chk("t1_reset", {bus.an_n, bus.seg_n, bus.dp_n}, {4'hF, 7'h7F, 1'b1});
    push(4'hE, 7'h01, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_still_blank", {8'h00, bus.an_n}, {8'h00, 4'hF});
    @(posedge clk);
    #1;
    chk("t1_first_lit", {8'h00, bus.an_n}, {8'h00, 4'hE});
    drain();

    // T2: basic scan
    run(16'h1234, 4'b0000, 1'b0, 1'b0, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);
    // T3: hex letters vs dash
    run(16'h00AF, 4'b0000, 1'b1, 1'b0, 7'b0111000, 7'b0001000, 7'b0000001, 7'b0000001);
    run(16'h00AF, 4'b0000, 1'b0, 1'b0, 7'b1111110, 7'b1111110, 7'b0000001, 7'b0000001);
    run(16'hBCDE, 4'b0000, 1'b1, 1'b0, 7'b0110000, 7'b1000010, 7'b0110001, 7'b1100000);
    // T4: leading-zero blanking; dp on a blanked digit still lights
    run(16'h0050, 4'b0100, 1'b0, 1'b1, 7'b0000001, 7'b0100100, 7'h7F, 7'h7F);
    run(16'h0050, 4'b0000, 1'b0, 1'b0, 7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001);

    // T5: mid-slot load waits for the wrap; load on the wrap cycle shows in the very next slot
    @(negedge clk);
    rst_n     = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    repeat (2) @(negedge clk);
    push(4'hE, 7'b0000001, 1'b1);
    push(4'hD, 7'b1001111, 1'b1);
    push(4'hB, 7'b0010010, 1'b1);
    push(4'h7, 7'b0010010, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.value = 16'h1111;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (11) @(negedge clk);
    bus.value = 16'h2222;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    drain();

    // T6: async reset mid-slot drops outputs at once and discards the pending load
    run(16'h8765, 4'b0010, 1'b0, 1'b0, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000);
    n = 0;
    while (bus.an_n == 4'hF && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_lit_before_reset", {11'h000, bus.an_n != 4'hF}, {11'h000, 1'b1});
    bus.value = 16'h9999;
    bus.dp_in = 4'b1111;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_dark", {bus.an_n, bus.seg_n, bus.dp_n}, {4'hF, 7'h7F, 1'b1});
    push(4'hE, 7'b0000001, 1'b1);
    push(4'hD, 7'b0000001, 1'b1);
    push(4'hB, 7'b0000001, 1'b1);
    push(4'h7, 7'b0000001, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
